// File: rtl/tetris_pkg.sv
// Shared types for the tetris playfield: board geometry, cell/piece/command encodings and FSM states.
package tetris_pkg;

   localparam int ROWS = 20;
   localparam int COLS = 10;

   typedef logic [2:0] cell_t;

   typedef enum logic [2:0] {
      PC_I, PC_O, PC_T, PC_S, PC_Z, PC_J, PC_L
   } piece_t;

   typedef enum logic [2:0] {
      CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_ROT_CW, CMD_SOFT, CMD_HARD
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SPAWN, ST_ACTIVE, ST_DROP, ST_LOCK, ST_SCAN, ST_OVER
   } state_t;

   // row 0 is the top of the well, col 0 the left wall
   typedef cell_t [ROWS-1:0][COLS-1:0] board_t;

endpackage

// File: rtl/tetris_shape_rom.sv
// Combinational tetromino shape table: four (dx,dy) cell offsets inside a 4x4 box.
module tetris_shape_rom
   import tetris_pkg::*;
(
   input  piece_t     type_i,
   input  logic [1:0] rot_i,
   output logic [7:0] dx_o,
   output logic [7:0] dy_o
);

   // each nibble is one cell as {dx[1:0], dy[1:0]}
   logic [15:0] cells;

   always_comb begin
      cells = 16'h159D;
      case (type_i)
         PC_I: begin
            case (rot_i)
               2'd0:    cells = 16'h159D;
               2'd1:    cells = 16'h89AB;
               2'd2:    cells = 16'h26AE;
               default: cells = 16'h4567;
            endcase
         end
         PC_O: cells = 16'h4859;
         PC_T: begin
            case (rot_i)
               2'd0:    cells = 16'h48C9;
               2'd1:    cells = 16'h89A5;
               2'd2:    cells = 16'h859D;
               default: cells = 16'h89AD;
            endcase
         end
         PC_S: cells = rot_i[0] ? 16'h89DE : 16'h8C59;
         PC_Z: cells = rot_i[0] ? 16'hC9DA : 16'h489D;
         PC_J: begin
            case (rot_i)
               2'd0:    cells = 16'h459D;
               2'd1:    cells = 16'h8C9A;
               2'd2:    cells = 16'h59DE;
               default: cells = 16'h896A;
            endcase
         end
         PC_L: begin
            case (rot_i)
               2'd0:    cells = 16'hC59D;
               2'd1:    cells = 16'h89AE;
               2'd2:    cells = 16'h59D6;
               default: cells = 16'h489A;
            endcase
         end
         default: cells = 16'h159D;
      endcase
   end

   always_comb begin
      dx_o = '0;
      dy_o = '0;
      for (int i = 0; i < 4; i++) begin
         dx_o[2*i +: 2] = cells[4*i+2 +: 2];
         dy_o[2*i +: 2] = cells[4*i +: 2];
      end
   end

endmodule

// File: rtl/tetris_board.sv
// Playfield owner: falling piece, collisions, locking, row clears and game over.
// Optional wall kick on rotation when TETRIS_WALL_KICK_EN is defined.
//
// state     | meaning
// IDLE      | waiting for start after reset
// SPAWN     | load next piece at the top; illegal spawn ends the game
// ACTIVE    | piece falls on ticks and obeys commands
// DROP      | hard drop, one row per cycle until blocked
// LOCK      | piece cells written into the board
// SCAN      | bottom-up full-row search and collapse
// OVER      | game over, waiting for start
module tetris_board
   import tetris_pkg::*;
#(
   parameter int SPAWN_X = 3
)(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        start,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd,
   output logic        cmd_ready,
   input  logic        tick,
   input  logic [2:0]  next_piece,
   output logic        next_req,
   output board_t      grid,
   output logic [15:0] lines,
   output logic        game_over
);

   state_t            state_q, state_d;
   board_t            board_q, board_d, grid_q, grid_d;
   piece_t            type_q, type_d;
   logic [1:0]        rot_q, rot_d;
   logic signed [4:0] x_q, x_d;
   logic signed [5:0] y_q, y_d;
   logic              pend_q, pend_d;
   logic [4:0]        row_q, row_d;
   logic [15:0]       lines_q, lines_d;

   piece_t            spawn_type, cand_type;
   cmd_t              cmd_e;
   logic [1:0]        cand_rot;
   logic signed [7:0] cand_x, cand_y;
   logic [7:0]        cand_dx, cand_dy, cur_dx, cur_dy;
   logic [3:0][3:0]   cur_col;
   logic [3:0][4:0]   cur_row;
   cell_t             piece_cell;
   logic              cmd_acc, fit0, row_full;

   function automatic logic fits(board_t b, logic [7:0] dx, logic [7:0] dy,
                                 logic signed [7:0] bx, logic signed [7:0] by);
      logic              ok;
      logic signed [7:0] c, r;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c = bx + $signed({6'd0, dx[2*i +: 2]});
         r = by + $signed({6'd0, dy[2*i +: 2]});
         if (c[7] || r[7] || c >= 8'(COLS) || r >= 8'(ROWS)) ok = 1'b0;
         else if (b[r[4:0]][c[3:0]] != '0)                     ok = 1'b0;
      end
      return ok;
   endfunction

   assign spawn_type = (next_piece == 3'd7) ? PC_I : piece_t'(next_piece);
   assign cmd_e      = cmd_t'(cmd);
   assign cmd_acc    = (state_q == ST_ACTIVE) && !pend_q && cmd_valid;
   assign piece_cell = type_q + 3'd1;

   // one candidate position per cycle: spawn, the accepted command, or a gravity step
   always_comb begin
      cand_type = type_q;
      cand_rot  = rot_q;
      cand_x    = 8'(x_q);
      cand_y    = 8'(y_q) + 8'sd1;
      if (state_q == ST_SPAWN) begin
         cand_type = spawn_type;
         cand_rot  = 2'd0;
         cand_x    = 8'(SPAWN_X);
         cand_y    = '0;
      end else if (cmd_acc) begin
         case (cmd_e)
            CMD_LEFT:   begin cand_x = 8'(x_q) - 8'sd1; cand_y = 8'(y_q); end
            CMD_RIGHT:  begin cand_x = 8'(x_q) + 8'sd1; cand_y = 8'(y_q); end
            CMD_ROT_CW: begin cand_rot = rot_q + 2'd1;  cand_y = 8'(y_q); end
            default:    ;
         endcase
      end
   end

   tetris_shape_rom u_rom_cand (.type_i(cand_type), .rot_i(cand_rot), .dx_o(cand_dx), .dy_o(cand_dy));
   tetris_shape_rom u_rom_cur  (.type_i(type_q),    .rot_i(rot_q),    .dx_o(cur_dx),  .dy_o(cur_dy));

   assign fit0 = fits(board_q, cand_dx, cand_dy, cand_x, cand_y);
`ifdef TETRIS_WALL_KICK_EN
   logic fit_l, fit_r;
   assign fit_l = fits(board_q, cand_dx, cand_dy, cand_x - 8'sd1, cand_y);
   assign fit_r = fits(board_q, cand_dx, cand_dy, cand_x + 8'sd1, cand_y);
`endif

   // the committed piece is always legal, so modular cell arithmetic is exact
   always_comb begin
      cur_col = '0;
      cur_row = '0;
      for (int i = 0; i < 4; i++) begin
         cur_col[i] = x_q[3:0] + {2'b00, cur_dx[2*i +: 2]};
         cur_row[i] = y_q[4:0] + {3'b000, cur_dy[2*i +: 2]};
      end
   end

   always_comb begin
      row_full = 1'b1;
      for (int c = 0; c < COLS; c++)
         if (board_q[row_q][c] == '0) row_full = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      board_d = board_q;
      type_d  = type_q;
      rot_d   = rot_q;
      x_d     = x_q;
      y_d     = y_q;
      pend_d  = 1'b0;
      row_d   = row_q;
      lines_d = lines_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_SPAWN;
         ST_SPAWN: begin
            type_d  = spawn_type;
            rot_d   = 2'd0;
            x_d     = 5'(SPAWN_X);
            y_d     = '0;
            state_d = fit0 ? ST_ACTIVE : ST_OVER;
         end
         ST_ACTIVE: begin
            if (pend_q) begin
               if (fit0) begin
                  y_d    = cand_y[5:0];
                  pend_d = tick;
               end else begin
                  state_d = ST_LOCK;
               end
            end else begin
               pend_d = tick;
               if (cmd_valid) begin
                  case (cmd_e)
                     CMD_LEFT, CMD_RIGHT: if (fit0) x_d = cand_x[4:0];
                     CMD_ROT_CW: begin
                        if (fit0) rot_d = cand_rot;
`ifdef TETRIS_WALL_KICK_EN
                        else if (fit_l) begin rot_d = cand_rot; x_d = 5'(cand_x - 8'sd1); end
                        else if (fit_r) begin rot_d = cand_rot; x_d = 5'(cand_x + 8'sd1); end
`endif
                     end
                     CMD_SOFT: begin
                        if (fit0) y_d = cand_y[5:0];
                        else      state_d = ST_LOCK;
                     end
                     CMD_HARD: state_d = ST_DROP;
                     default:  ;
                  endcase
               end
            end
         end
         ST_DROP: begin
            if (fit0) y_d = cand_y[5:0];
            else      state_d = ST_LOCK;
         end
         ST_LOCK: begin
            for (int i = 0; i < 4; i++) board_d[cur_row[i]][cur_col[i]] = piece_cell;
            row_d   = 5'(ROWS - 1);
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (row_full) begin
               for (int r = ROWS - 1; r > 0; r--)
                  if (5'(r) <= row_q) board_d[r] = board_q[r-1];
               board_d[0] = '0;
               if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
            end else if (row_q == '0) begin
               state_d = ST_SPAWN;
            end else begin
               row_d = row_q - 5'd1;
            end
         end
         ST_OVER: begin
            if (start) begin
               board_d = '0;
               lines_d = '0;
               state_d = ST_SPAWN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      grid_d = board_q;
      if (state_q == ST_ACTIVE || state_q == ST_DROP)
         for (int i = 0; i < 4; i++) grid_d[cur_row[i]][cur_col[i]] = piece_cell;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         board_q <= '0;
         grid_q  <= '0;
         type_q  <= PC_I;
         rot_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         pend_q  <= 1'b0;
         row_q   <= '0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         grid_q  <= grid_d;
         type_q  <= type_d;
         rot_q   <= rot_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pend_q  <= pend_d;
         row_q   <= row_d;
         lines_q <= lines_d;
      end
   end

   assign grid      = grid_q;
   assign lines     = lines_q;
   assign game_over = (state_q == ST_OVER);
   assign next_req  = (state_q == ST_SPAWN);
   assign cmd_ready = (state_q == ST_ACTIVE) && !pend_q;

endmodule

// File: tb/tb_tetris_board.sv
// Directed self-checking bench for tetris_board: spawn, walls, rotation, tick/command overlap,
// line clear, game over and asynchronous reset.
module tb_tetris_board;
   import tetris_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        start = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [2:0]  cmd = 3'd0;
   logic        tick = 1'b0;
   logic [2:0]  next_piece = 3'd0;
   logic        cmd_ready, next_req, game_over;
   board_t      grid;
   logic [15:0] lines;

   int     n_chk = 0;
   int     n_fail = 0;
   int     n_req = 0;
   int     req0;
   board_t e;

   tetris_board #(.SPAWN_X(3)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start), .cmd_valid(cmd_valid), .cmd(cmd),
      .cmd_ready(cmd_ready), .tick(tick), .next_piece(next_piece), .next_req(next_req),
      .grid(grid), .lines(lines), .game_over(game_over)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) if (next_req === 1'b1) n_req++;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_grid(input string tag, input board_t exp);
      n_chk++;
      assert (grid === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, grid, exp);
      end
   endtask

   task automatic send(input logic [2:0] c);
      cmd_valid = 1'b1;
      cmd = c;
      step();
      cmd_valid = 1'b0;
      cmd = 3'd0;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      start = 1'b0;
      cmd_valid = 1'b0;
      tick = 1'b0;
      repeat (2) step();
      Reset_n = 1'b1;
      step();
   endtask

   task automatic start_game(input logic [2:0] p);
      next_piece = p;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
   endtask

   task automatic wait_spawn(input string tag, input logic [2:0] p);
      int k;
      next_piece = p;
      k = 0;
      while (next_req !== 1'b1 && k < 200) begin
         step();
         k++;
      end
      chk(tag, 32'(next_req), 32'd1);
   endtask

   initial begin
      // reset state
      repeat (3) step();
      e = '0;
      chk_grid("rst_grid", e);
      chk("rst_lines", 32'(lines), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_req", 32'(next_req), 32'd0);
      Reset_n = 1'b1;
      step();

      // spawn a T
      next_piece = 3'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("spawn_req", 32'(next_req), 32'd1);
      chk("spawn_ready", 32'(cmd_ready), 32'd0);
      step();
      chk("spawn_req_end", 32'(next_req), 32'd0);
      chk("spawn_ready_act", 32'(cmd_ready), 32'd1);
      chk_grid("spawn_grid_lag", e);
      step();
      e[0][4] = 3'd3; e[0][5] = 3'd3; e[0][6] = 3'd3; e[1][5] = 3'd3;
      chk_grid("spawn_grid_t", e);

      // lone gravity tick
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("tick_ready_lo", 32'(cmd_ready), 32'd0);
      step();
      chk("tick_ready_hi", 32'(cmd_ready), 32'd1);
      step();
      e = '0;
      e[1][4] = 3'd3; e[1][5] = 3'd3; e[1][6] = 3'd3; e[2][5] = 3'd3;
      chk_grid("tick_grid", e);

      // I piece pushed into the left wall, start ignored while active
      do_reset();
      start_game(3'd0);
      cmd_valid = 1'b1;
      cmd = CMD_LEFT;
      repeat (10) step();
      cmd_valid = 1'b0;
      chk("wall_ready", 32'(cmd_ready), 32'd1);
      step();
      e = '0;
      for (int c = 0; c < 4; c++) e[1][c] = 3'd1;
      chk_grid("wall_grid", e);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_ignored", 32'(next_req), 32'd0);
      chk_grid("start_ignored_grid", e);

      // vertical I against the wall: rotation into the wall is rejected
      send(CMD_ROT_CW);
      send(CMD_LEFT);
      send(CMD_LEFT);
      send(CMD_LEFT);
      send(CMD_ROT_CW);
      step();
      e = '0;
      for (int r = 0; r < 4; r++) e[r][0] = 3'd1;
      chk_grid("rot_reject_grid", e);

      // tick together with an accepted RIGHT
      do_reset();
      start_game(3'd2);
      cmd_valid = 1'b1;
      cmd = CMD_RIGHT;
      tick = 1'b1;
      step();
      cmd_valid = 1'b0;
      tick = 1'b0;
      chk("sim_ready_lo", 32'(cmd_ready), 32'd0);
      e = '0;
      e[0][4] = 3'd3; e[0][5] = 3'd3; e[0][6] = 3'd3; e[1][5] = 3'd3;
      chk_grid("sim_grid0", e);
      step();
      chk("sim_ready_hi", 32'(cmd_ready), 32'd1);
      e = '0;
      e[0][5] = 3'd3; e[0][6] = 3'd3; e[0][7] = 3'd3; e[1][6] = 3'd3;
      chk_grid("sim_grid_x", e);
      step();
      e = '0;
      e[1][5] = 3'd3; e[1][6] = 3'd3; e[1][7] = 3'd3; e[2][6] = 3'd3;
      chk_grid("sim_grid_y", e);

      // line clear: two flat I pieces and an O complete row 19
      do_reset();
      start_game(3'd0);
      send(CMD_LEFT);
      send(CMD_LEFT);
      send(CMD_LEFT);
      send(CMD_HARD);
      chk("drop_ready", 32'(cmd_ready), 32'd0);
      wait_spawn("lc_spawn1", 3'd0);
      chk("lc_lines0", 32'(lines), 32'd0);
      step();
      send(CMD_RIGHT);
      send(CMD_HARD);
      wait_spawn("lc_spawn2", 3'd1);
      e = '0;
      for (int c = 0; c < 8; c++) e[19][c] = 3'd1;
      chk_grid("lc_grid_pre", e);
      step();
      repeat (4) send(CMD_RIGHT);
      send(CMD_HARD);
      wait_spawn("lc_spawn3", 3'd2);
      chk("lc_lines1", 32'(lines), 32'd1);
      e = '0;
      e[19][8] = 3'd2; e[19][9] = 3'd2;
      chk_grid("lc_grid_post", e);

      // asynchronous reset in the middle of a game
      #3;
      Reset_n = 1'b0;
      #1;
      e = '0;
      chk_grid("areset_grid", e);
      chk("areset_lines", 32'(lines), 32'd0);
      chk("areset_req", 32'(next_req), 32'd0);

      // game over: stack O pieces in the spawn columns
      do_reset();
      req0 = n_req;
      start_game(3'd1);
      for (int k = 0; k < 10; k++) begin
         send(CMD_HARD);
         wait_spawn("go_spawn", 3'd1);
         step();
      end
      chk("go_over", 32'(game_over), 32'd1);
      chk("go_ready", 32'(cmd_ready), 32'd0);
      chk("go_req_cnt", 32'(n_req - req0), 32'd11);
      repeat (3) step();
      chk("go_req_cnt_hold", 32'(n_req - req0), 32'd11);
      chk("go_lines", 32'(lines), 32'd0);
      e = '0;
      for (int r = 0; r < ROWS; r++) begin
         e[r][4] = 3'd2;
         e[r][5] = 3'd2;
      end
      chk_grid("go_grid", e);

      // restart from OVER clears the board
      next_piece = 3'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_over", 32'(game_over), 32'd0);
      chk("restart_req", 32'(next_req), 32'd1);
      chk("restart_lines", 32'(lines), 32'd0);
      step();
      e = '0;
      chk_grid("restart_grid_clear", e);
      step();
      e[0][4] = 3'd3; e[0][5] = 3'd3; e[0][6] = 3'd3; e[1][5] = 3'd3;
      chk_grid("restart_grid_t", e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
